// File: rtl/cnt_cmd_sched.sv
// ---------------------------------------------------------------------------
// cnt_cmd_sched
//
// Shares one up/down/load counter between two requesters. A granted command
// drives the counter mode `m` (and `pin` for LOAD) for exactly N cycles. One
// WAIT cycle follows with the counter idle. Then the counter value is captured
// into `rdata` and the granted requester receives a one-cycle ack.
//
// Handshake: a requester raises reqX with cmdX/argX stable and holds all three
// until ackX pulses. The command is taken on the first posedge in IDLE where
// reqX is high. Dropping reqX afterwards does not abort the command. A reqX
// still high on the posedge that ends the ack cycle starts a new command.
//
// Optional feature (macro ARB_RR_EN):
//   defined   - round-robin between the two requesters (last-grant tracked)
//   undefined - fixed priority, req0 highest; no last-grant register
//
// Ports:
//   clk        clock; scheduler on posedge, counter on negedge
//   rst        asynchronous active-low reset
//   req0/1     command request
//   cmd0/1     opcode: 0 NOP/read, 1 INC, 2 DEC, 3 LOAD
//   arg0/1     step count (INC/DEC) or load value (LOAD)
//   ack0/1     one-cycle completion pulse
//   rdata      counter value captured at completion
//   busy       high whenever the scheduler is not IDLE
//   m          counter mode
//   pin        counter parallel-load value
//   fout       counter current value
//   state_dbg  current FSM state (IDLE=0, EXEC=1, WAIT=2)
// ---------------------------------------------------------------------------
module cnt_cmd_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [1:0]   cmd0,
    input  logic [1:0]   cmd1,
    input  logic [W-1:0] arg0,
    input  logic [W-1:0] arg1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] rdata,
    output logic         busy,
    output logic [1:0]   m,
    output logic [W-1:0] pin,
    input  logic [W-1:0] fout,
    output logic [1:0]   state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd3;

    logic [1:0]   state;
    logic         gnt_q;     // requester currently being served
    logic [1:0]   cmd_q;
    logic [W-1:0] arg_q;
    logic [W-1:0] rem;

    // Arbitration and decode of the winning command
    logic         any_req;
    logic         gnt_sel;   // 0 = req0 wins, 1 = req1 wins
    logic [1:0]   sel_cmd;
    logic [W-1:0] sel_arg;
    logic [W-1:0] sel_n;

`ifdef ARB_RR_EN
    logic last_gnt;

    always_comb begin
        gnt_sel = 1'b0;
        if (req1 && (!req0 || !last_gnt))
            gnt_sel = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_gnt <= 1'b1;
        else if (state == S_IDLE && any_req)
            last_gnt <= gnt_sel;
    end
`else
    always_comb begin
        gnt_sel = 1'b0;
        if (req1 && !req0)
            gnt_sel = 1'b1;
    end
`endif

    always_comb begin
        any_req = req0 | req1;
        sel_cmd = gnt_sel ? cmd1 : cmd0;
        sel_arg = gnt_sel ? arg1 : arg0;
        // LOAD occupies the counter for one cycle, NOP for none
        case (sel_cmd)
            OP_NOP:  sel_n = '0;
            OP_LOAD: sel_n = W'(1);
            default: sel_n = sel_arg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            gnt_q <= 1'b0;
            cmd_q <= OP_NOP;
            arg_q <= '0;
            rem   <= '0;
            m     <= 2'd0;
            pin   <= '0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            rdata <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q <= gnt_sel;
                        cmd_q <= sel_cmd;
                        arg_q <= sel_arg;
                        rem   <= sel_n;
                        if (sel_n != '0) begin
                            // Mode is registered here so the counter sees it
                            // on the very next negedge.
                            state <= S_EXEC;
                            m     <= sel_cmd;
                            pin   <= (sel_cmd == OP_LOAD) ? sel_arg : '0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_EXEC: begin
                    rem <= rem - W'(1);
                    if (rem == W'(1)) begin
                        state <= S_WAIT;
                        m     <= 2'd0;
                        pin   <= '0;
                    end else begin
                        m     <= cmd_q;
                        pin   <= (cmd_q == OP_LOAD) ? arg_q : '0;
                    end
                end
                S_WAIT: begin
                    // Counter's last negedge update has settled by now
                    rdata <= fout;
                    ack0  <= ~gnt_q;
                    ack1  <= gnt_q;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    m     <= 2'd0;
                    pin   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_cnt_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_cnt_cmd_sched
//
// Directed bench for cnt_cmd_sched with a behavioural negedge counter attached
// to m/pin/fout. Expected values are hand-computed. Understands ARB_RR_EN for
// the arbitration expectations.
// ---------------------------------------------------------------------------
module tb_cnt_cmd_sched;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         req0, req1;
    logic [1:0]   cmd0, cmd1;
    logic [W-1:0] arg0, arg1;
    logic         ack0, ack1;
    logic [W-1:0] rdata;
    logic         busy;
    logic [1:0]   m;
    logic [W-1:0] pin;
    logic [W-1:0] fout;
    logic [1:0]   state_dbg;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counter model ----------------
    logic [W-1:0] cnt = '0;
    always @(negedge clk) begin
        case (m)
            2'd1: cnt <= cnt + 8'd1;
            2'd2: cnt <= cnt - 8'd1;
            2'd3: cnt <= pin;
            default: cnt <= cnt;
        endcase
    end
    assign fout = cnt;

    cnt_cmd_sched #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .cmd0      (cmd0),
        .cmd1      (cmd1),
        .arg0      (arg0),
        .arg1      (arg1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .m         (m),
        .pin       (pin),
        .fout      (fout),
        .state_dbg (state_dbg)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic v);
        if (id == 0) req0 = v;
        else         req1 = v;
    endtask

    // Issue one command and follow it cycle by cycle through the ack.
    // drop_at >= 0 releases req early, after that many cycles past sampling.
    task automatic run_cmd(input int id, input logic [1:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] exp_rdata, input int drop_at);
        int n;
        logic [W-1:0] exp_pin;
        n = (c == 2'd0) ? 0 : (c == 2'd3) ? 1 : int'(a);
        exp_pin = (c == 2'd3) ? a : 8'h00;
        if (id == 0) begin cmd0 = c; arg0 = a; end
        else         begin cmd1 = c; arg1 = a; end
        set_req(id, 1'b1);
        for (int i = 0; i <= n + 1; i++) begin
            step();
            if (i < n) begin
                chk($sformatf("m_exec%0d_c%0d_i%0d", id, c, i), {30'd0, m}, {30'd0, c});
                chk($sformatf("pin_exec%0d_i%0d", id, i), {24'd0, pin}, {24'd0, exp_pin});
                chk($sformatf("state_exec%0d_i%0d", id, i), {30'd0, state_dbg}, 32'd1);
                chk($sformatf("ack_early%0d_i%0d", id, i), {30'd0, ack1, ack0}, 32'd0);
            end else if (i == n) begin
                chk($sformatf("m_wait%0d_c%0d", id, c), {30'd0, m}, 32'd0);
                chk($sformatf("busy_wait%0d", id), {31'd0, busy}, 32'd1);
                chk($sformatf("state_wait%0d", id), {30'd0, state_dbg}, 32'd2);
                chk($sformatf("ack_wait%0d", id), {30'd0, ack1, ack0}, 32'd0);
            end else begin
                chk($sformatf("ack_done%0d", id), {30'd0, ack1, ack0}, (id == 0) ? 32'd1 : 32'd2);
                chk($sformatf("busy_done%0d", id), {31'd0, busy}, 32'd0);
                chk($sformatf("rdata_done%0d_c%0d", id, c), {24'd0, rdata}, {24'd0, exp_rdata});
                set_req(id, 1'b0);
            end
            if (i == drop_at) set_req(id, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] arb_rd  [3];
    int           arb_id  [3];
    int           nack;

    initial begin
        rst  = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        cmd0 = 2'd0; cmd1 = 2'd0;
        arg0 = '0;   arg1 = '0;
        #1;
        chk("rst_m",     {30'd0, m},        32'd0);
        chk("rst_pin",   {24'd0, pin},      32'd0);
        chk("rst_ack",   {30'd0, ack1, ack0}, 32'd0);
        chk("rst_rdata", {24'd0, rdata},    32'd0);
        chk("rst_busy",  {31'd0, busy},     32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();

        // LOAD, INC, wrap-around DEC, zero-length INC
        run_cmd(0, 2'd3, 8'h5A, 8'h5A, -1);
        run_cmd(1, 2'd1, 8'd3,  8'h5D, -1);
        run_cmd(0, 2'd3, 8'h00, 8'h00, -1);
        run_cmd(0, 2'd2, 8'd1,  8'hFF, -1);
        run_cmd(1, 2'd1, 8'd0,  8'hFF, -1);

        // Both requesters held: req0 INC 1, req1 INC 2. Last grant was req1.
`ifdef ARB_RR_EN
        arb_id = '{0, 1, 0};
        arb_rd = '{8'h00, 8'h02, 8'h03};
`else
        arb_id = '{0, 0, 0};
        arb_rd = '{8'h00, 8'h01, 8'h02};
`endif
        cmd0 = 2'd1; arg0 = 8'd1;
        cmd1 = 2'd1; arg1 = 8'd2;
        req0 = 1'b1; req1 = 1'b1;
        nack = 0;
        for (int cyc = 0; cyc < 30 && nack < 3; cyc++) begin
            step();
            if (ack0 || ack1) begin
                chk($sformatf("arb_id%0d", nack), {30'd0, ack1, ack0},
                    (arb_id[nack] == 0) ? 32'd1 : 32'd2);
                chk($sformatf("arb_rdata%0d", nack), {24'd0, rdata}, {24'd0, arb_rd[nack]});
                nack++;
                if (nack == 3) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("arb_ack_count", nack, 32'd3);
        step();
        step();
        chk("arb_idle", {31'd0, busy}, 32'd0);

        // Reset mid-command: INC 10 from 0, reset after 5 EXEC cycles
        run_cmd(0, 2'd3, 8'h00, 8'h00, -1);
        cmd0 = 2'd1; arg0 = 8'd10; req0 = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        chk("midrst_m_before", {30'd0, m}, 32'd1);
        rst = 1'b0;
        #1;
        req0 = 1'b0;
        chk("midrst_m",     {30'd0, m},     32'd0);
        chk("midrst_pin",   {24'd0, pin},   32'd0);
        chk("midrst_busy",  {31'd0, busy},  32'd0);
        chk("midrst_rdata", {24'd0, rdata}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("midrst_noack%0d", i), {30'd0, ack1, ack0}, 32'd0);
        end
        rst = 1'b1;
        step();
        chk("midrst_cnt", {24'd0, cnt}, 32'd5);

        // req0 dropped right after sampling: INC 4 still completes, one ack
        run_cmd(0, 2'd1, 8'd4, 8'h09, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("drop_single_ack%0d", i), {30'd0, ack1, ack0}, 32'd0);
        end
        chk("drop_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
